// File: rtl/serial_subtractor_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_subtractor_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/half_subtractor.sv
// Half subtractor: single-bit a - b with borrow out.
module half_subtractor (
  input  logic a,
  input  logic b,
  output logic diff,
  output logic bout
);

  // Difference bit and borrow are pure combinational functions of the inputs.
  assign diff = a ^ b;
  assign bout = ~a & b;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: diff = a - b over WIDTH cycles using one
// full-subtractor cell (two half subtractors) and a registered borrow.
// Optional feature macro: SERIAL_SUBTRACTOR_OVF_EN adds a registered signed
// overflow output (ovf).
//
//   state | meaning
//   IDLE  | waiting for start; outputs hold the last result
//   SHIFT | one bit of a - b processed per cycle, LSB first
//   DONE  | result final, done pulses; a start here begins the next operation
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  output logic             ovf,
`endif
  output logic             bout
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  state_t           state_next;
  logic             load;
  logic             shift_en;
  logic             last_bit;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_shift;
  logic             borrow;
  logic [CNT_W-1:0] cnt;

  logic             hs0_diff;
  logic             hs0_bout;
  logic             cell_diff;
  logic             hs1_bout;
  logic             borrow_next;

  half_subtractor u_hs0 (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .diff (hs0_diff),
    .bout (hs0_bout)
  );

  half_subtractor u_hs1 (
    .a    (hs0_diff),
    .b    (borrow),
    .diff (cell_diff),
    .bout (hs1_bout)
  );

  assign borrow_next = hs0_bout | hs1_bout;
  assign last_bit    = (cnt == CNT_LAST);

  // The new bit enters at the MSB so the result lines up after WIDTH shifts.
  if (WIDTH == 1) begin : g_res_one
    assign res_shift = cell_diff;
  end else begin : g_res_multi
    assign res_shift = {cell_diff, res[WIDTH-1:1]};
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and datapath control. DONE always leaves after one cycle; a
  // start seen there is accepted directly, giving one operation per WIDTH+1
  // cycles when start is held high.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    shift_en   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        shift_en = 1'b1;
        if (last_bit) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (start) begin
          load       = 1'b1;
          state_next = SHIFT;
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Operand shift registers, result register, borrow flop and bit counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res    <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
    end else if (load) begin
      a_sr   <= a;
      b_sr   <= b;
      borrow <= 1'b0;
      cnt    <= '0;
    end else if (shift_en) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      res    <= res_shift;
      borrow <= borrow_next;
      cnt    <= cnt + CNT_W'(1);
    end
  end

`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic a_msb;
  logic b_msb;
  logic ovf_q;

  // Operand sign bits are latched at accept; overflow is resolved on the
  // last bit, when the cell output is the result sign bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      ovf_q <= 1'b0;
    end else if (load) begin
      a_msb <= a[WIDTH-1];
      b_msb <= b[WIDTH-1];
    end else if (shift_en && last_bit) begin
      ovf_q <= (a_msb ^ b_msb) & (a_msb ^ cell_diff);
    end
  end

  assign ovf = ovf_q;
`endif

  assign busy = (state == SHIFT);
  assign done = (state == DONE);
  assign diff = res;
  assign bout = borrow;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=8 instance plus a WIDTH=1 instance).
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;

  logic         start1 = 1'b0;
  logic [0:0]   a1 = '0;
  logic [0:0]   b1 = '0;
  logic         busy1;
  logic         done1;
  logic [0:0]   diff1;
  logic         bout1;

`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic         ovf;
  logic         ovf1;
`endif

  int n_vec = 0;
  int n_err = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    .ovf   (ovf),
`endif
    .bout  (bout)
  );

  serial_subtractor #(.WIDTH(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start1),
    .a     (a1),
    .b     (b1),
    .busy  (busy1),
    .done  (done1),
    .diff  (diff1),
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    .ovf   (ovf1),
`endif
    .bout  (bout1)
  );

  always #5 clk = ~clk;

  // Pulses start for one accepting edge, then watches W+3 edges and reports
  // the first edge (relative to accept) where done was high and what was seen.
  task automatic do_op(input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                       output logic [W-1:0] r_diff, output logic r_bout,
                       output logic r_ovf, output logic r_busy,
                       output int r_edge, output int r_count);
    r_diff = '0; r_bout = 1'b0; r_ovf = 1'b0; r_busy = 1'b1;
    r_edge = -1; r_count = 0;
    @(negedge clk);
    start = 1'b1; a = op_a; b = op_b;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= W + 3; k++) begin
      @(posedge clk); #1;
      if (done) begin
        r_count++;
        if (r_edge < 0) begin
          r_edge = k; r_diff = diff; r_bout = bout; r_busy = busy;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
          r_ovf = ovf;
`endif
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; a = 8'd10; b = 8'd3;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b want=0", busy); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b want=0", done); end
    n_vec++; if (diff !== 8'd0) begin n_err++; $display("FAIL reset_diff got=%0d want=0", diff); end
    n_vec++; if (bout !== 1'b0) begin n_err++; $display("FAIL reset_bout got=%b want=0", bout); end
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    n_vec++; if (ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf got=%b want=0", ovf); end
`endif
    start = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_vec++; if (busy !== 1'b0 || done !== 1'b0)
      begin n_err++; $display("FAIL idle_after_reset busy=%b done=%b want 0/0", busy, done); end
  endtask

  task automatic test_basic();
    logic [W-1:0] rd; logic rb, ro, rbz; int re, rc;
    do_op(8'd10, 8'd3, rd, rb, ro, rbz, re, rc);
    n_vec++; if (re !== 8) begin n_err++; $display("FAIL basic_done_edge got=%0d want=8", re); end
    n_vec++; if (rc !== 1) begin n_err++; $display("FAIL basic_done_count got=%0d want=1", rc); end
    n_vec++; if (rd !== 8'd7) begin n_err++; $display("FAIL basic_diff got=%0d want=7", rd); end
    n_vec++; if (rb !== 1'b0) begin n_err++; $display("FAIL basic_bout got=%b want=0", rb); end
    n_vec++; if (rbz !== 1'b0) begin n_err++; $display("FAIL basic_busy_at_done got=%b want=0", rbz); end
    n_vec++; if (diff !== 8'd7 || bout !== 1'b0)
      begin n_err++; $display("FAIL basic_hold got=%0d/%b want=7/0", diff, bout); end
  endtask

  task automatic test_borrow();
    logic [W-1:0] rd; logic rb, ro, rbz; int re, rc;
    logic [W-1:0] va [3] = '{8'd3, 8'd0, 8'd255};
    logic [W-1:0] vb [3] = '{8'd10, 8'd1, 8'd255};
    logic [W-1:0] ed [3] = '{8'd249, 8'd255, 8'd0};
    logic         eb [3] = '{1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      do_op(va[i], vb[i], rd, rb, ro, rbz, re, rc);
      n_vec++; if (rd !== ed[i] || rb !== eb[i] || re !== 8)
        begin n_err++; $display("FAIL borrow_vec%0d got=%0d/%b@%0d want=%0d/%b@8", i, rd, rb, re, ed[i], eb[i]); end
    end
  endtask

`ifdef SERIAL_SUBTRACTOR_OVF_EN
  task automatic test_ovf();
    logic [W-1:0] rd; logic rb, ro, rbz; int re, rc;
    do_op(8'h80, 8'h01, rd, rb, ro, rbz, re, rc);
    n_vec++; if (rd !== 8'h7F || ro !== 1'b1)
      begin n_err++; $display("FAIL ovf_set got=%h/%b want=7f/1", rd, ro); end
    n_vec++; if (ovf !== 1'b1) begin n_err++; $display("FAIL ovf_hold got=%b want=1", ovf); end
    do_op(8'h05, 8'h03, rd, rb, ro, rbz, re, rc);
    n_vec++; if (rd !== 8'h02 || ro !== 1'b0)
      begin n_err++; $display("FAIL ovf_clear got=%h/%b want=02/0", rd, ro); end
  endtask
`endif

  task automatic test_ignore_start();
    int first = -1; int cnt = 0;
    logic [W-1:0] rd = '0; logic rb = 1'b0;
    @(negedge clk);
    start = 1'b1; a = 8'd10; b = 8'd3;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= W + 3; k++) begin
      @(posedge clk); #1;
      if (done) begin
        cnt++;
        if (first < 0) begin first = k; rd = diff; rb = bout; end
      end
      if (k == 2) begin start = 1'b1; a = 8'hFF; b = 8'h00; end
      if (k == 5) start = 1'b0;
    end
    n_vec++; if (cnt !== 1 || first !== 8)
      begin n_err++; $display("FAIL ignore_done got=%0d pulses@%0d want=1@8", cnt, first); end
    n_vec++; if (rd !== 8'd7 || rb !== 1'b0)
      begin n_err++; $display("FAIL ignore_result got=%0d/%b want=7/0", rd, rb); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL ignore_idle got busy=%b want=0", busy); end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] rd; logic rb, ro, rbz; int re, rc;
    @(negedge clk);
    start = 1'b1; a = 8'd10; b = 8'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++; if (busy !== 1'b0 || done !== 1'b0)
      begin n_err++; $display("FAIL midreset_ctrl got=%b/%b want=0/0", busy, done); end
    n_vec++; if (diff !== 8'd0 || bout !== 1'b0)
      begin n_err++; $display("FAIL midreset_data got=%0d/%b want=0/0", diff, bout); end
    @(negedge clk);
    rst_n = 1'b1;
    do_op(8'd0, 8'd0, rd, rb, ro, rbz, re, rc);
    n_vec++; if (rd !== 8'd0 || rb !== 1'b0 || re !== 8)
      begin n_err++; $display("FAIL after_midreset got=%0d/%b@%0d want=0/0@8", rd, rb, re); end
  endtask

  task automatic test_back_to_back();
    int edges [3] = '{-1, -1, -1};
    logic [W-1:0] ds [3] = '{8'd0, 8'd0, 8'd0};
    logic bs [3] = '{1'b0, 1'b0, 1'b0};
    int cnt = 0;
    @(negedge clk);
    start = 1'b1; a = 8'd200; b = 8'd100;
    @(posedge clk); #1;
    a = 8'd0; b = 8'd1;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      if (done) begin
        if (cnt < 3) begin edges[cnt] = k; ds[cnt] = diff; bs[cnt] = bout; end
        cnt++;
      end
      if (k == 9) begin a = 8'd255; b = 8'd255; end
      if (k == 18) start = 1'b0;
    end
    n_vec++; if (cnt !== 3) begin n_err++; $display("FAIL b2b_count got=%0d want=3", cnt); end
    n_vec++; if (edges[0] !== 8 || edges[1] !== 17 || edges[2] !== 26)
      begin n_err++; $display("FAIL b2b_edges got=%0d,%0d,%0d want=8,17,26", edges[0], edges[1], edges[2]); end
    n_vec++; if (ds[0] !== 8'd100 || bs[0] !== 1'b0)
      begin n_err++; $display("FAIL b2b_op0 got=%0d/%b want=100/0", ds[0], bs[0]); end
    n_vec++; if (ds[1] !== 8'd255 || bs[1] !== 1'b1)
      begin n_err++; $display("FAIL b2b_op1 got=%0d/%b want=255/1", ds[1], bs[1]); end
    n_vec++; if (ds[2] !== 8'd0 || bs[2] !== 1'b0)
      begin n_err++; $display("FAIL b2b_op2 got=%0d/%b want=0/0", ds[2], bs[2]); end
  endtask

  task automatic test_width1();
    logic [0:0] va [2] = '{1'b1, 1'b0};
    logic [0:0] vb [2] = '{1'b0, 1'b1};
    logic       eb [2] = '{1'b0, 1'b1};
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      start1 = 1'b1; a1 = va[i]; b1 = vb[i];
      @(posedge clk); #1;
      start1 = 1'b0;
      n_vec++; if (busy1 !== 1'b1 || done1 !== 1'b0)
        begin n_err++; $display("FAIL w1_shift%0d got busy=%b done=%b want=1/0", i, busy1, done1); end
      @(posedge clk); #1;
      n_vec++; if (done1 !== 1'b1 || busy1 !== 1'b0 || diff1 !== 1'b1 || bout1 !== eb[i])
        begin n_err++; $display("FAIL w1_done%0d got done=%b busy=%b diff=%b bout=%b want=1/0/1/%b",
                                i, done1, busy1, diff1, bout1, eb[i]); end
      @(posedge clk); #1;
      n_vec++; if (done1 !== 1'b0) begin n_err++; $display("FAIL w1_idle%0d got done=%b want=0", i, done1); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_borrow();
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    test_ovf();
`endif
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    test_width1();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
